// File: rtl/uart_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_defs
// Description : Shared UART definitions: RX FSM state encodings and the
//               clocks-per-bit rounding helper used by both RX and TX sides.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_defs;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_divisor(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer with a parameterized reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_stream_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_stream_rx
// Description : 8N1 UART receiver presenting bytes on a one-entry valid/ready
//               output register, with frame-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_stream_rx
    import uart_defs::*;
#(
    parameter int         CLK_FREQ_HZ = 16000000,
    parameter int         BAUD_RATE   = 57600,
    parameter logic [7:0] LAST_BYTE   = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int DIVISOR = calc_divisor(CLK_FREQ_HZ, BAUD_RATE);
    localparam int TMR_W   = $clog2(DIVISOR);

    localparam logic [TMR_W-1:0] c_HALF_BIT = TMR_W'(DIVISOR / 2 - 1);
    localparam logic [TMR_W-1:0] c_FULL_BIT = TMR_W'(DIVISOR - 1);

    if (DIVISOR < 4) begin : g_divisor_check
        $error("uart_stream_rx: DIVISOR must be at least 4");
    end

    logic             w_rx_s;
    logic             w_tick;
    logic             w_byte_done;
    logic             w_stop_bad;
    logic [2:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_tdata;
    logic             r_tlast;
    logic             r_tvalid;
    logic             r_frame_err;
    logic             r_overrun;

    uart_rx_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_uart_rx),
        .o_q   (w_rx_s)
    );

    assign w_tick      = (r_timer == '0);
    assign w_byte_done = (r_state == ST_STOP) && w_tick && w_rx_s;
    assign w_stop_bad  = (r_state == ST_STOP) && w_tick && !w_rx_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_timer <= c_HALF_BIT;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (!w_tick) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer   <= c_FULL_BIT;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!w_tick) begin
                        r_timer <= r_timer - 1'b1;
                    end else begin
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_timer   <= c_FULL_BIT;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!w_tick) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A completed byte is accepted only if the slot is empty or being drained.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_byte_done) begin
                if (!r_tvalid || i_tready) begin
                    r_tdata  <= r_shift;
                    r_tlast  <= (r_shift == LAST_BYTE);
                    r_tvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_tvalid && i_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign o_tdata     = r_tdata;
    assign o_tlast     = r_tlast;
    assign o_tvalid    = r_tvalid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_stream_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_stream_rx
// Description : Directed self-checking bench for uart_stream_rx (DIVISOR=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_stream_rx;
    import uart_defs::*;

    localparam int c_CLK_HZ = 1600000;
    localparam int c_BAUD   = 100000;
    localparam int c_BIT    = 16;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rx     = 1'b1;
    logic       tready = 1'b0;
    logic [7:0] tdata;
    logic       tlast;
    logic       tvalid;
    logic       frame_err;
    logic       overrun;

    int n_compared   = 0;
    int n_mismatched = 0;

    int cyc = 0;
    int valid_cycles, valid_seen, first_valid_cyc;
    int hs_count, fe_count, ov_count, unstable;
    logic [7:0] hs_data, prev_data;
    logic       hs_last, prev_last, prev_hold;

    uart_stream_rx #(
        .CLK_FREQ_HZ (c_CLK_HZ),
        .BAUD_RATE   (c_BAUD),
        .LAST_BYTE   (8'h0A)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uart_rx   (rx),
        .o_tdata     (tdata),
        .o_tlast     (tlast),
        .o_tvalid    (tvalid),
        .i_tready    (tready),
        .o_frame_err (frame_err),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tvalid) valid_cycles++;
        if (tvalid && valid_seen == 0) begin
            valid_seen      = 1;
            first_valid_cyc = cyc;
        end
        if (tvalid && tready) begin
            hs_count++;
            hs_data = tdata;
            hs_last = tlast;
        end
        if (frame_err) fe_count++;
        if (overrun)   ov_count++;
        if (prev_hold && (!tvalid || tdata != prev_data || tlast != prev_last)) unstable++;
        prev_hold = tvalid && !tready;
        prev_data = tdata;
        prev_last = tlast;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        valid_cycles = 0; valid_seen = 0; first_valid_cyc = 0;
        hs_count = 0; fe_count = 0; ov_count = 0; unstable = 0;
        hs_data = 8'h00; hs_last = 1'b0; prev_hold = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        rx = 1'b0;
        wait_cyc(c_BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(c_BIT);
        end
        rx = stopb;
        wait_cyc(c_BIT);
    endtask

    initial begin
        int start_cyc;
        clear_mon();
        wait_cyc(3);
        @(negedge clk);
        check_eq("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check_eq("rst_tdata", {24'd0, tdata}, 32'd0);
        check_eq("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(20);

        // Single byte with permanent ready
        tready = 1'b1;
        clear_mon();
        start_cyc = cyc;
        send_frame(8'h55, 1'b1);
        wait_cyc(20);
        check_eq("t1_hs_count", hs_count, 1);
        check_eq("t1_data", {24'd0, hs_data}, 32'h55);
        check_eq("t1_last", {31'd0, hs_last}, 32'd0);
        check_eq("t1_valid_cycles", valid_cycles, 1);
        check_eq("t1_latency", (first_valid_cyc - start_cyc <= 156) &&
                               (first_valid_cyc - start_cyc >= 150), 1);

        // Last marker under backpressure
        tready = 1'b0;
        clear_mon();
        send_frame(8'h0A, 1'b1);
        wait_cyc(100);
        @(negedge clk);
        check_eq("t2_tvalid", {31'd0, tvalid}, 32'd1);
        check_eq("t2_tdata", {24'd0, tdata}, 32'h0A);
        check_eq("t2_tlast", {31'd0, tlast}, 32'd1);
        wait_cyc(1);
        tready = 1'b1;
        wait_cyc(1);
        tready = 1'b0;
        @(negedge clk);
        check_eq("t2_drop_after_hs", {31'd0, tvalid}, 32'd0);
        check_eq("t2_stable", unstable, 0);
        wait_cyc(10);

        // Overrun on the second of two back-to-back frames
        clear_mon();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        wait_cyc(10);
        @(negedge clk);
        check_eq("t3_overrun_count", ov_count, 1);
        check_eq("t3_tdata", {24'd0, tdata}, 32'h12);
        check_eq("t3_tvalid", {31'd0, tvalid}, 32'd1);
        wait_cyc(1);
        tready = 1'b1;
        wait_cyc(1);
        tready = 1'b0;
        wait_cyc(10);

        // Replace: ready asserted in exactly the completion cycle of byte two
        send_frame(8'h12, 1'b1);
        clear_mon();
        fork
            send_frame(8'h34, 1'b1);
            begin
                wait_cyc(154);
                tready = 1'b1;
                wait_cyc(1);
                tready = 1'b0;
            end
        join
        wait_cyc(5);
        @(negedge clk);
        check_eq("t4_tdata", {24'd0, tdata}, 32'h34);
        check_eq("t4_tvalid", {31'd0, tvalid}, 32'd1);
        check_eq("t4_overrun", ov_count, 0);
        check_eq("t4_handshake", hs_count, 1);
        wait_cyc(1);
        tready = 1'b1;
        wait_cyc(10);

        // Framing error followed by a long break, then a good frame
        clear_mon();
        send_frame(8'hA5, 1'b0);
        wait_cyc(40 * c_BIT);
        rx = 1'b1;
        wait_cyc(2 * c_BIT);
        check_eq("t5_frame_err", fe_count, 1);
        check_eq("t5_no_valid", valid_cycles, 0);
        send_frame(8'h3C, 1'b1);
        wait_cyc(10);
        check_eq("t5_recover_count", hs_count, 1);
        check_eq("t5_recover_data", {24'd0, hs_data}, 32'h3C);

        // Short low glitch is rejected
        clear_mon();
        rx = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        wait_cyc(40);
        check_eq("t6_glitch_valid", valid_cycles, 0);
        check_eq("t6_glitch_fe", fe_count, 0);
        check_eq("t6_glitch_idle", {29'd0, dut.r_state}, {29'd0, ST_IDLE});

        // Reset during data bits aborts the frame
        clear_mon();
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_cyc(60);
                rst = 1'b1;
                wait_cyc(2);
                rst = 1'b0;
            end
        join
        wait_cyc(20);
        @(negedge clk);
        check_eq("t6_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check_eq("t6_rst_tdata", {24'd0, tdata}, 32'd0);
        check_eq("t6_rst_tlast", {31'd0, tlast}, 32'd0);
        check_eq("t6_rst_no_byte", valid_cycles, 0);
        wait_cyc(1);
        send_frame(8'h81, 1'b1);
        wait_cyc(10);
        check_eq("t6_after_count", hs_count, 1);
        check_eq("t6_after_data", {24'd0, hs_data}, 32'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_stream_rx.md
# uart_stream_rx

UART receiver that converts an asynchronous 8N1 serial line into an 8-bit valid/ready byte stream, with the same stream signalling used by the byte producers feeding the UART emitter. It sits at the board boundary on the RX pin and gives the SoC side a host-to-FPGA command/data path. Each received byte is held in a one-entry output register until the consumer accepts it. Framing errors and overruns are flagged with single-cycle pulses.

## Interface
- CLK_FREQ_HZ, 16000000, frequency of i_clk in Hz
- BAUD_RATE, 57600, line bit rate
- LAST_BYTE, 8'h0A, received value that asserts o_tlast alongside its byte
- Derived localparam DIVISOR = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, i.e. clocks per bit rounded to nearest; must be ≥ 4

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset; synchronous, active-high
- i_uart_rx  input  1  asynchronous serial line, idle high
- o_tdata  output  8  received byte
- o_tlast  output  1  high with o_tdata when o_tdata == LAST_BYTE
- o_tvalid  output  1  byte available
- i_tready  input  1  consumer accepts byte when high with o_tvalid
- o_frame_err  output  1  one-cycle pulse on a bad stop bit
- o_overrun  output  1  one-cycle pulse when a completed byte is dropped

## Operation
- Input path: two-flop synchronizer on i_uart_rx. Both flops reset to 1. All logic uses the synchronized value rx_s.
- Bit timer: down-counter of width clog2(DIVISOR). Bit index is 3 bits. Shift register is 8 bits and shifts in LSB first.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s == 0, load timer with DIVISOR/2 − 1 and go to START.
  - START: at timer == 0, sample rx_s.
    - If rx_s == 1, treat it as a glitch and return to IDLE with no flags.
    - Otherwise load timer with DIVISOR − 1, clear the bit index, and go to DATA.
  - DATA: at timer == 0, shift rx_s into the MSB (bit order is LSB first on the line) and reload DIVISOR − 1. After the 8th bit (index 7), go to STOP.
  - STOP: at timer == 0, sample rx_s.
    - If rx_s == 1, the byte is complete; go to IDLE.
    - If rx_s == 0, pulse o_frame_err, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This absorbs break conditions.
- Output register:
  - Byte complete while o_tvalid == 0: load o_tdata, set o_tlast = (byte == LAST_BYTE), set o_tvalid.
  - Byte complete with o_tvalid && i_tready in the same cycle: the new byte replaces the old one and o_tvalid stays high. No overrun.
  - Byte complete with o_tvalid && !i_tready: keep the old byte, drop the new byte, pulse o_overrun.
  - Handshake with no new byte: clear o_tvalid.
- o_tdata and o_tlast are stable while o_tvalid && !i_tready. o_tvalid never drops without a handshake.

## Timing
- Reset values:
  - o_tvalid = 0, o_tdata = 0, o_tlast = 0, o_frame_err = 0, o_overrun = 0
  - FSM = IDLE, synchronizer = 1
- i_rst mid-frame aborts immediately. Any pending byte is lost. The next frame is recognized only after a fresh falling edge is seen in IDLE.
- Detection latency: rx_s falls 2 cycles after a pin edge.
- Sample points: the start bit is sampled DIVISOR/2 cycles after rx_s falls. Each subsequent bit is sampled DIVISOR cycles after the previous one.
- o_tvalid rises, or o_overrun/o_frame_err pulses, in the cycle after the stop-bit sample.
- The consumer may hold i_tready high permanently; every byte is then presented for exactly one cycle.
- Back-to-back frames: IDLE re-arms in the cycle after the stop sample, so a start edge arriving half a bit later is caught.

## Structure
- Shared package/include uart_defs: FSM state encodings and the DIVISOR rounding function. The emitter side reuses the function.
- One sub-module: uart_rx_sync, a 2-flop synchronizer with parameterized reset value.
- The FSM, timer, and output register stay in uart_stream_rx.

## Test plan
All scenarios use CLK_FREQ_HZ = 1600000 and BAUD_RATE = 100000, so DIVISOR = 16.
- **Single byte:** send 0x55 with i_tready = 1 → o_tvalid high for 1 cycle with o_tdata = 0x55 and o_tlast = 0, within 9.5 bit times + 4 cycles of the start edge.
- **Last marker and backpressure:** send 0x0A with i_tready = 0 for 100 cycles → o_tvalid high, o_tdata = 0x0A, o_tlast = 1 held stable until i_tready rises; o_tvalid drops in the cycle after the handshake.
- **Overrun:** send 0x12 then 0x34 back-to-back with i_tready = 0 → o_overrun pulses once at the end of the second frame; o_tdata stays 0x12.
- **Replace on handshake:** send 0x34 as in the overrun case, but assert i_tready in exactly the completion cycle of the second byte → o_tdata = 0x34, o_tvalid stays high, o_overrun = 0.
- **Framing error and break:** send 0xA5 with stop bit = 0, then hold the line low for 40 bit times → one o_frame_err pulse and no o_tvalid; the next valid frame 0x3C is received correctly.
- **Glitch and mid-frame reset:** a 4-cycle low glitch → no output, FSM back in IDLE. Assert i_rst during the data bits of 0xFF → all outputs at reset values; the following frame 0x81 is received correctly.
